// File: rtl/action_queue_encoder.sv
// -----------------------------------------------------------------------------
// action_queue_encoder
//
// Purpose:
//    Samples a one-hot player action bus every clock and detects new presses.
//    Each press is encoded to a binary action code and queued in a small FIFO.
//    The most-significant bit of the bus maps to code 1, and the least-significant
//    bit maps to code NUM_ACTIONS. Code 0 means "no action".
//    Game logic drains the FIFO through a valid/ready handshake.
//    Multi-hot (illegal) patterns and pushes into a full FIFO are reported as
//    one-cycle pulses. Neither kind of input is queued.
//
// Optional feature (compile-time macro ACTION_REPEAT_EN):
//    When the macro is defined, a held one-hot input re-queues its code every
//    REPEAT_CYCLES clocks. When it is undefined, no repeat counter is built,
//    and a held input yields exactly one entry.
//
// Ports:
//    i_clk          in   1               system clock, rising edge
//    i_rst          in   1               asynchronous active-high reset
//    i_in           in   NUM_ACTIONS     one-hot action request (0 = none)
//    i_act_ready    in   1               consumer takes the head entry
//    o_act_valid    out  1               FIFO non-empty
//    o_act_code     out  CODE_W          head-of-FIFO code (0 when empty)
//    o_count        out  clog2(DEPTH)+1  entries currently held
//    o_err_illegal  out  1               pulse: new multi-hot pattern seen
//    o_overflow     out  1               pulse: press dropped, FIFO full
//    o_drop_cnt     out  8               saturating count of dropped presses
// -----------------------------------------------------------------------------
module action_queue_encoder #(
   parameter int NUM_ACTIONS   = 6,
   parameter int CODE_W        = 3,
   parameter int DEPTH         = 4,
   parameter int REPEAT_CYCLES = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [NUM_ACTIONS-1:0]     i_in,
   input  logic                       i_act_ready,
   output logic                       o_act_valid,
   output logic [CODE_W-1:0]          o_act_code,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_err_illegal,
   output logic                       o_overflow,
   output logic [7:0]                 o_drop_cnt
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [NUM_ACTIONS-1:0] r_in_q;
   logic [CODE_W-1:0]      r_mem [DEPTH];
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic                   r_err_illegal;
   logic                   r_overflow;
   logic [7:0]             r_drop_cnt;

   // ------------------------------------------------------------------------
   // Input classification
   // ------------------------------------------------------------------------
   logic                   w_nonzero;
   logic                   w_onehot;
   logic                   w_multi;
   logic                   w_changed;
   logic                   w_press;
   logic                   w_illegal_evt;
   logic [CODE_W-1:0]      w_code;

   assign w_nonzero = (i_in != '0);
   // Clearing the lowest set bit leaves zero only for a single-bit pattern.
   assign w_onehot  = w_nonzero &&
                      ((i_in & (i_in - NUM_ACTIONS'(1))) == '0);
   assign w_multi   = w_nonzero && !w_onehot;
   assign w_changed = (i_in != r_in_q);

   assign w_press       = w_onehot && w_changed;
   assign w_illegal_evt = w_multi  && w_changed;

   // MSB of the bus is code 1; the LSB is code NUM_ACTIONS.
   always_comb begin
      w_code = '0;
      for (int i = 0; i < NUM_ACTIONS; i++) begin
         if (i_in[NUM_ACTIONS-1-i]) begin
            w_code = CODE_W'(i + 1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Optional auto-repeat
   // ------------------------------------------------------------------------
   logic w_repeat_fire;

`ifdef ACTION_REPEAT_EN
   localparam int RC_W = $clog2(REPEAT_CYCLES + 1);

   logic [RC_W-1:0] r_rep_cnt;
   logic            w_held;

   // Same one-hot value as last cycle: the only case that may count.
   assign w_held = w_onehot && !w_changed;

   // The counter reads k after the k-th edge following the press.
   // The re-push therefore lands exactly REPEAT_CYCLES edges after the
   // previous push.
   assign w_repeat_fire = w_held && (r_rep_cnt == RC_W'(REPEAT_CYCLES - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rep_cnt <= '0;
      end else if (!w_held || w_repeat_fire) begin
         r_rep_cnt <= '0;
      end else begin
         r_rep_cnt <= r_rep_cnt + RC_W'(1);
      end
   end
`else
   assign w_repeat_fire = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------------
   logic w_full;
   logic w_empty;
   logic w_push_req;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   assign w_push_req = w_press || w_repeat_fire;
   assign w_pop      = !w_empty && i_act_ready;
   // A pop frees the slot on the same edge, so a full FIFO still accepts a push.
   // An empty FIFO never bypasses: the new head appears on the next cycle.
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && w_full && !w_pop;

   // Storage has no reset; emptiness is carried entirely by the pointers.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= w_code;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_in_q        <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_err_illegal <= 1'b0;
         r_overflow    <= 1'b0;
         r_drop_cnt    <= '0;
      end else begin
         r_in_q        <= i_in;
         r_err_illegal <= w_illegal_evt;
         r_overflow    <= w_drop;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign o_act_valid   = !w_empty;
   assign o_act_code    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign o_count       = r_wr_ptr - r_rd_ptr;
   assign o_err_illegal = r_err_illegal;
   assign o_overflow    = r_overflow;
   assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_action_queue_encoder.sv
module tb_action_queue_encoder;

   logic       clk;
   logic       rst;
   logic [5:0] in_bus;
   logic       act_ready;
   logic       act_valid;
   logic [2:0] act_code;
   logic [2:0] count;
   logic       err_illegal;
   logic       overflow;
   logic [7:0] drop_cnt;

   int total;
   int bad;

   action_queue_encoder #(
      .NUM_ACTIONS   (6),
      .CODE_W        (3),
      .DEPTH         (4),
      .REPEAT_CYCLES (16)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_in          (in_bus),
      .i_act_ready   (act_ready),
      .o_act_valid   (act_valid),
      .o_act_code    (act_code),
      .o_count       (count),
      .o_err_illegal (err_illegal),
      .o_overflow    (overflow),
      .o_drop_cnt    (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_bus = '0; act_ready = 1'b0;
      step();
      step();
      total++;
      if (act_valid !== 1'b0 || act_code !== 3'd0 || count !== 3'd0 ||
          err_illegal !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
         bad++;
         $display("FAIL reset_state: valid=%0b code=%0d count=%0d err=%0b ovf=%0b drop=%0d required all 0",
                  act_valid, act_code, count, err_illegal, overflow, drop_cnt);
      end
      rst = 1'b0;
      step();
      $display("reset: valid=%0b count=%0d drop=%0d", act_valid, count, drop_cnt);
   endtask

   task automatic test_single_hold();
      in_bus = 6'b100000; act_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         total++;
         if (act_valid !== 1'b1 || act_code !== 3'd1 || count !== 3'd1) begin
            bad++;
            $display("FAIL hold_cycle%0d: valid=%0b code=%0d count=%0d required 1/1/1",
                     c, act_valid, act_code, count);
         end
         $display("hold cycle %0d: valid=%0b code=%0d count=%0d", c, act_valid, act_code, count);
      end
      in_bus = '0; act_ready = 1'b1;
      step();
      total++;
      if (act_valid !== 1'b0 || count !== 3'd0 || act_code !== 3'd0) begin
         bad++;
         $display("FAIL hold_drain: valid=%0b count=%0d code=%0d required 0/0/0",
                  act_valid, count, act_code);
      end
      act_ready = 1'b0;
   endtask

   task automatic test_order();
      logic [5:0] pat [3];
      logic [2:0] exp [3];
      pat[0] = 6'b000010; pat[1] = 6'b000001; pat[2] = 6'b010000;
      exp[0] = 3'd5;      exp[1] = 3'd6;      exp[2] = 3'd2;
      act_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_bus = pat[k];
         step();
      end
      in_bus = '0;
      for (int k = 0; k < 4; k++) step();
      total++;
      if (count !== 3'd3) begin
         bad++;
         $display("FAIL order_stall_count: count=%0d required 3", count);
      end
      act_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (act_valid !== 1'b1 || act_code !== exp[k] || count !== 3'(3 - k)) begin
            bad++;
            $display("FAIL order_pop%0d: valid=%0b code=%0d count=%0d required 1/%0d/%0d",
                     k, act_valid, act_code, count, exp[k], 3 - k);
         end
         $display("pop %0d: code=%0d count=%0d", k, act_code, count);
         step();
      end
      total++;
      if (count !== 3'd0 || act_valid !== 1'b0) begin
         bad++;
         $display("FAIL order_empty: count=%0d valid=%0b required 0/0", count, act_valid);
      end
      act_ready = 1'b0;
   endtask

   task automatic test_illegal();
      in_bus = 6'b011000;
      step();
      total++;
      if (err_illegal !== 1'b1 || count !== 3'd0 || act_valid !== 1'b0) begin
         bad++;
         $display("FAIL illegal_pulse: err=%0b count=%0d valid=%0b required 1/0/0",
                  err_illegal, count, act_valid);
      end
      $display("illegal: err=%0b count=%0d", err_illegal, count);
      step();
      total++;
      if (err_illegal !== 1'b0 || count !== 3'd0) begin
         bad++;
         $display("FAIL illegal_held: err=%0b count=%0d required 0/0", err_illegal, count);
      end
      in_bus = '0;
      step();
   endtask

   task automatic test_overflow();
      logic [5:0] pat [4];
      pat[0] = 6'b100000; pat[1] = 6'b010000; pat[2] = 6'b001000; pat[3] = 6'b000100;
      act_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_bus = pat[k];
         step();
      end
      total++;
      if (count !== 3'd4 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL ovf_fill: count=%0d ovf=%0b required 4/0", count, overflow);
      end
      in_bus = 6'b000010;
      step();
      total++;
      if (overflow !== 1'b1 || drop_cnt !== 8'd1 || count !== 3'd4) begin
         bad++;
         $display("FAIL ovf_drop: ovf=%0b drop=%0d count=%0d required 1/1/4",
                  overflow, drop_cnt, count);
      end
      $display("overflow: ovf=%0b drop=%0d count=%0d", overflow, drop_cnt, count);
      in_bus = 6'b000001; act_ready = 1'b1;
      step();
      total++;
      if (overflow !== 1'b0 || drop_cnt !== 8'd1 || count !== 3'd4 || act_code !== 3'd2) begin
         bad++;
         $display("FAIL ovf_push_pop: ovf=%0b drop=%0d count=%0d code=%0d required 0/1/4/2",
                  overflow, drop_cnt, count, act_code);
      end
      act_ready = 1'b0; in_bus = '0;
      step();
   endtask

   task automatic test_async_reset();
      act_ready = 1'b1;
      for (int k = 0; k < 5; k++) step();
      act_ready = 1'b0;
      in_bus = 6'b100000; step();
      in_bus = 6'b010000; step();
      in_bus = 6'b001000; step();
      total++;
      if (count !== 3'd3) begin
         bad++;
         $display("FAIL arst_setup: count=%0d required 3", count);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if (act_valid !== 1'b0 || count !== 3'd0 || drop_cnt !== 8'd0) begin
         bad++;
         $display("FAIL arst_immediate: valid=%0b count=%0d drop=%0d required 0/0/0",
                  act_valid, count, drop_cnt);
      end
      $display("async reset: valid=%0b count=%0d", act_valid, count);
      @(negedge clk);
      rst = 1'b0;
      step();
      total++;
      if (count !== 3'd1 || act_code !== 3'd3 || act_valid !== 1'b1) begin
         bad++;
         $display("FAIL arst_held_event: count=%0d code=%0d valid=%0b required 1/3/1",
                  count, act_code, act_valid);
      end
      step();
      total++;
      if (count !== 3'd1) begin
         bad++;
         $display("FAIL arst_held_once: count=%0d required 1", count);
      end
      in_bus = '0; act_ready = 1'b1;
      step();
      act_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      in_bus = 6'b000100; step();
      in_bus = '0;        step();
      in_bus = 6'b000100; step();
      in_bus = '0;        step();
      step();
      total++;
      if (count !== 3'd2 || act_code !== 3'd4) begin
         bad++;
         $display("FAIL b2b_count: count=%0d code=%0d required 2/4", count, act_code);
      end
      act_ready = 1'b1;
      step();
      total++;
      if (count !== 3'd1 || act_code !== 3'd4) begin
         bad++;
         $display("FAIL b2b_second: count=%0d code=%0d required 1/4", count, act_code);
      end
      step();
      total++;
      if (count !== 3'd0 || act_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_empty: count=%0d valid=%0b required 0/0", count, act_valid);
      end
      $display("back-to-back: drained count=%0d", count);
      act_ready = 1'b0;
   endtask

`ifdef ACTION_REPEAT_EN
   task automatic test_repeat();
      int got;
      int wrong;
      got = 0; wrong = 0;
      act_ready = 1'b1;
      in_bus = 6'b000100;
      for (int c = 0; c < 43; c++) begin
         if (c == 40) in_bus = '0;
         step();
         // The entry seen here is taken on the next rising edge.
         if (act_valid === 1'b1) begin
            got++;
            if (act_code !== 3'd4) wrong++;
         end
      end
      total++;
      if (got != 3 || wrong != 0) begin
         bad++;
         $display("FAIL repeat_count: delivered=%0d wrong_codes=%0d required 3/0", got, wrong);
      end
      $display("repeat: delivered=%0d", got);
      act_ready = 1'b0;
   endtask
`endif

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; in_bus = '0; act_ready = 1'b0;
      test_reset();
      test_single_hold();
      test_order();
      test_illegal();
      test_overflow();
      test_async_reset();
      test_back_to_back();
`ifdef ACTION_REPEAT_EN
      test_repeat();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/action_queue_encoder.md
Name: action_queue_encoder

Overview:
- Parametrised successor to the single-player one-hot action decoder.
- Samples a one-hot player action bus every clock and detects new presses. Each new press is encoded to a binary action code (0 = none, 1..NUM_ACTIONS) and buffered in a FIFO.
- Game logic drains the FIFO through a valid/ready handshake, so actions arriving faster than the game-state FSM consumes them are not lost.
- Illegal multi-hot inputs and FIFO overflows are flagged, not silently encoded.

Parameters:
- NUM_ACTIONS, 6, width of the one-hot action bus (j, k, p, w, mf, mb in the base game).
- CODE_W, 3, action code width; must satisfy 2**CODE_W > NUM_ACTIONS.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- REPEAT_CYCLES, 16, auto-repeat period in clocks; used only with ACTION_REPEAT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in  in  NUM_ACTIONS  one-hot action request; all-zero = none.
- act_ready  in  1  consumer accepts head entry this cycle.
- act_valid  out  1  FIFO non-empty; act_code is meaningful.
- act_code  out  CODE_W  head-of-FIFO action code.
- count  out  clog2(DEPTH)+1  entries currently held.
- err_illegal  out  1  one-cycle pulse: multi-hot pattern newly seen on in.
- overflow  out  1  one-cycle pulse: press dropped because FIFO full.
- drop_cnt  out  8  saturating count of overflow drops.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst is asynchronous and active-high; it clears everything immediately.
  - Reset values: in_q=0, FIFO empty, act_valid=0, act_code=0, count=0, err_illegal=0, overflow=0, drop_cnt=0.
- Encoding: in[NUM_ACTIONS-1-i] maps to code i+1 (MSB maps to 1, LSB maps to NUM_ACTIONS). Base game: j=1, k=2, p=3, w=4, mf=5, mb=6.
- Input register: in_q <= in every clock.
- Press event: in is exactly one-hot AND in != in_q.
  - A held input produces one event only.
  - Going directly from one one-hot value to a different one-hot value is a new event.
  - in == 0 never produces an event.
- Illegal input: popcount(in) >= 2 AND in != in_q.
  - err_illegal=1 for the next cycle (registered pulse); nothing is pushed.
  - A held illegal pattern pulses once.
- Push: on a press event with FIFO not full (or full with a simultaneous pop), the code is written at wr_ptr on that clock edge.
- Latency: in changes before edge N; act_valid=1 and act_code valid after edge N (1 clock).
- Pop: act_valid && act_ready at an edge advances rd_ptr. act_ready while empty is ignored.
- act_code: combinational read of the head entry. Holds 0 when empty.
- Pointers: clog2(DEPTH)+1 bits with natural wrap. full = MSBs differ and LSBs equal; empty = pointers equal.
- Simultaneous push and pop:
  - Empty: push only; the head appears next cycle, no bypass.
  - Full: both occur; count unchanged; no overflow.
- Overflow: event while full and no pop. The entry is dropped, overflow pulses for 1 cycle, and drop_cnt increments, saturating at 255.
- Ordering: strict FIFO order; no reordering and no priority.
- Reset mid-operation: all queued actions are discarded. The first post-reset cycle compares against in_q=0, so an action held through reset generates a fresh event.

Optional Feature:
- Macro: ACTION_REPEAT_EN.
- Defined:
  - A repeat counter clears on every press event and on any change of in.
  - While the same one-hot in is held, it counts clocks. When it reaches REPEAT_CYCLES, it re-pushes the same code (with normal overflow rules) and clears.
  - Illegal or zero inputs never repeat.
- Undefined: no counter is synthesised; a held input yields exactly one entry.

Test Plan:
- Reset, then in=6'b100000 held 5 cycles, act_ready=0 -> one entry; act_valid=1, act_code=1, count=1 from the first edge onward.
- Sequence 000010, 000001, 010000 on consecutive cycles with act_ready=1 after a 4-cycle stall -> pops in order: code 5, 6, 2; count drains 3→0.
- in=6'b011000 -> err_illegal pulses 1 cycle; count stays 0; act_valid stays 0.
- Fill 4 entries with act_ready=0, then a 5th distinct press -> overflow pulse, drop_cnt=1, count=4. Repeat with act_ready=1 on the same edge -> no overflow, count stays 4.
- Assert rst asynchronously mid-clock with 3 entries queued -> act_valid=0 and count=0 immediately. An action held through reset is queued once after release.
- With ACTION_REPEAT_EN and REPEAT_CYCLES=16, hold in=000100 for 40 cycles with act_ready=1 -> code 4 delivered 3 times (initial press, +16, +32).
